// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU path: sequencer states and
// the add/subtract operation encoding.
package serial_alu_pkg;

  // Sequencer states of the bit-serial adder.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Operation select carried on op_sub.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit combinational full adder, reused once per serial cycle.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. One full-adder cell processes one
// operand bit per cycle, LSB first, over WIDTH cycles. Subtraction is
// a + ~b + 1, so the inverted B operand and the carry-in of 1 are set
// up when the request is accepted.
module serial_add_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             sum;
  logic             cout;
  logic             last_bit;
  logic [WIDTH-1:0] result_next;

  serial_fa_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (cy),
    .sum  (sum),
    .cout (cout)
  );

  assign last_bit    = (cnt == CNT_LAST);
  assign result_next = {sum, result[WIDTH-1:1]};
  assign busy        = (state == S_RUN);
  assign done        = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE and in the DONE cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (last_bit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture, per-bit shifting and flag capture on the final bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= (op_sub == OP_ADD) ? b : ~b;
      cy   <= (op_sub == OP_SUB);
      cnt  <= '0;
    end else if (state == S_RUN) begin
      result <= result_next;
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      cy     <= cout;
      if (last_bit) begin
        cnt       <= '0;
        overflow  <= cy ^ cout;
        carry_out <= cout;
        zero      <= (result_next == '0);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
